jt8255_multi: RTL and testbench



---
 rtl/jt8255_multi.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_jt8255_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jt8255_multi.sv
// jt8255_multi -- multi-port 8255-style parallel interface.
//
// NPORTS independent DW-bit ports. Each port is configured by the CPU as input or
// output, in basic mode (direct latch / sample) or strobed mode (DEPTH-entry FIFO
// with peripheral handshake and a per-port interrupt). Port interrupts are ORed
// onto irq.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   addr              addr[0]=0 data, 1 control/status; port index = addr >> 1
//   din / dout        CPU write data / registered CPU read data
//   rdn, wrn, csn     active-low read, write and chip-select strobes
//   irq               registered OR of all port interrupts
//   port_din          peripheral input data, port p at [p*DW +: DW]
//   port_dout         peripheral output data, port p at [p*DW +: DW]
//   port_oe           1 = port drives its pins (output direction)
//   port_stb          input strobed mode: rising edge pushes port_din
//   port_ack          output strobed mode: rising edge pops the FIFO head
//   port_rdy          input strobed mode: FIFO not full
//   port_obf          output strobed mode: FIFO not empty
module jt8255_multi #(
  parameter int NPORTS = 3,
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(NPORTS) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        din,
  output logic [DW-1:0]        dout,
  input  logic                 rdn,
  input  logic                 wrn,
  input  logic                 csn,
  output logic                 irq,
  input  logic [NPORTS*DW-1:0] port_din,
  output logic [NPORTS*DW-1:0] port_dout,
  output logic [NPORTS-1:0]    port_oe,
  input  logic [NPORTS-1:0]    port_stb,
  input  logic [NPORTS-1:0]    port_ack,
  output logic [NPORTS-1:0]    port_rdy,
  output logic [NPORTS-1:0]    port_obf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                 w_read;
  logic                 w_write;
  logic                 w_rd_first;
  logic                 w_wr_commit;
  logic [AW-1:0]        w_rd_port;
  logic [AW-1:0]        w_wr_port;
  logic [NPORTS*DW-1:0] w_rd_val;
  logic [NPORTS-1:0]    w_intr;
  logic [DW-1:0]        w_rd_data;

  logic [DW-1:0]        r_din;
  logic [AW-1:0]        r_addr;
  logic                 r_last_write;
  logic                 r_last_read;
  logic [DW-1:0]        r_dout;
  logic                 r_irq;

  assign w_read      = !rdn && !csn;
  assign w_write     = !wrn && !csn;
  assign w_rd_first  = w_read && !r_last_read;
  // A write commits once the access ends, using the data/address captured
  // during its last active cycle.
  assign w_wr_commit = !w_write && r_last_write;
  assign w_rd_port   = addr >> 1;
  assign w_wr_port   = r_addr >> 1;

  assign dout = r_dout;
  assign irq  = r_irq;

  // Bus front end: capture write data/address and strobe history, load dout, register irq.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_din        <= {DW{1'b0}};
      r_addr       <= {AW{1'b0}};
      r_last_write <= 1'b0;
      r_last_read  <= 1'b0;
      r_dout       <= {DW{1'b1}};
      r_irq        <= 1'b0;
    end else begin
      r_din        <= din;
      r_addr       <= addr;
      r_last_write <= w_write;
      r_last_read  <= w_read;
      if (w_rd_first) begin
        r_dout <= w_rd_data;
      end else begin
        r_dout <= r_dout;
      end
      r_irq <= |w_intr;
    end
  end

  // Read mux: addressed port's value; indices beyond NPORTS read as zero.
  always_comb begin
    w_rd_data = {DW{1'b0}};
    for (int p = 0; p < NPORTS; p++) begin
      if (w_rd_port == AW'(p)) begin
        w_rd_data = w_rd_val[p*DW +: DW];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
  end

  for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
    logic          r_dir;
    logic          r_mode;
    logic          r_inte;
    logic          r_ovf;
    logic [DW-1:0] r_latch;
    logic [DW-1:0] r_pin;
    logic          r_last_stb;
    logic          r_last_ack;
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rdptr;
    logic [PW-1:0] r_wrptr;
    logic [CW-1:0] r_cnt;

    logic          w_sel_rd;
    logic          w_dat_rd;
    logic          w_st_rd;
    logic          w_sel_wr;
    logic          w_ctl_wr;
    logic          w_dat_wr;
    logic          w_empty;
    logic          w_full;
    logic          w_st_empty;
    logic          w_st_full;
    logic [DW-1:0] w_pin;
    logic [DW-1:0] w_head;
    logic          w_stb_rise;
    logic          w_ack_rise;
    logic          w_push;
    logic          w_pop_req;
    logic [DW-1:0] w_push_data;
    logic          w_pass;
    logic          w_do_pop;
    logic          w_do_push;
    logic          w_drop;
    logic          w_clear;
    logic [DW-1:0] w_val;
    logic [DW-1:0] w_pdout;

    assign w_pin      = port_din[gp*DW +: DW];
    assign w_sel_rd   = w_rd_first && (w_rd_port == AW'(gp));
    assign w_dat_rd   = w_sel_rd && !addr[0];
    assign w_st_rd    = w_sel_rd && addr[0];
    assign w_sel_wr   = w_wr_commit && (w_wr_port == AW'(gp));
    assign w_ctl_wr   = w_sel_wr && r_addr[0];
    assign w_dat_wr   = w_sel_wr && !r_addr[0];
    assign w_empty    = (r_cnt == {CW{1'b0}});
    assign w_full     = (r_cnt == CW'(DEPTH));
    // FIFO flags are only meaningful (and reported) in strobed mode.
    assign w_st_empty = r_mode && w_empty;
    assign w_st_full  = r_mode && w_full;
    assign w_head     = r_mem[r_rdptr];
    assign w_stb_rise = port_stb[gp] && !r_last_stb;
    assign w_ack_rise = port_ack[gp] && !r_last_ack;

    // Route push/pop requests according to direction in strobed mode.
    always_comb begin
      w_push      = 1'b0;
      w_pop_req   = 1'b0;
      w_push_data = w_pin;
      if (r_mode) begin
        if (r_dir) begin
          w_push      = w_stb_rise;
          w_pop_req   = w_dat_rd;
          w_push_data = w_pin;
        end else begin
          w_push      = w_dat_wr;
          w_pop_req   = w_ack_rise;
          w_push_data = r_din;
        end
      end else begin
        w_push    = 1'b0;
        w_pop_req = 1'b0;
      end
    end

    // Pop goes first: on an empty FIFO a simultaneous push is consumed at once
    // (w_pass), on a full FIFO the pop frees the slot for the push.
    assign w_pass    = w_push && w_pop_req && w_empty;
    assign w_do_pop  = w_pop_req && !w_empty;
    assign w_do_push = w_push && !w_pass && (!w_full || w_do_pop);
    assign w_drop    = w_push && w_full && !w_do_pop;
    assign w_clear   = w_ctl_wr && ((r_din[0] != r_dir) || (r_din[1] != r_mode) || r_din[3]);

    assign w_intr[gp] = r_mode && r_inte && (r_dir ? !w_empty : !w_full);

    // CPU-visible value for this port (status or data, depending on addr[0]).
    always_comb begin
      w_val = {DW{1'b0}};
      if (addr[0]) begin
        w_val = {{(DW-7){1'b0}}, r_ovf, w_intr[gp], w_st_empty, w_st_full, r_inte, r_mode, r_dir};
      end else if (!r_mode) begin
        w_val = r_dir ? w_pin : r_latch;
      end else if (r_dir) begin
        w_val = w_pass ? w_pin : (w_empty ? {DW{1'b0}} : w_head);
      end else begin
        w_val = w_empty ? {DW{1'b1}} : w_head;
      end
    end

    // Pin-side output value built purely from port registers.
    always_comb begin
      w_pdout = {DW{1'b1}};
      if (!r_mode) begin
        w_pdout = r_dir ? r_pin : r_latch;
      end else if (!r_dir) begin
        w_pdout = w_empty ? {DW{1'b1}} : w_head;
      end else begin
        w_pdout = {DW{1'b1}};
      end
    end

    assign w_rd_val[gp*DW +: DW]  = w_val;
    assign port_dout[gp*DW +: DW] = w_pdout;
    assign port_oe[gp]            = !r_dir;
    assign port_rdy[gp]           = r_mode && r_dir && !w_full;
    assign port_obf[gp]           = r_mode && !r_dir && !w_empty;

    // Port state: configuration, latch, pin sample, edge history, FIFO pointers and overflow.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_dir      <= 1'b1;
        r_mode     <= 1'b0;
        r_inte     <= 1'b0;
        r_ovf      <= 1'b0;
        r_latch    <= {DW{1'b1}};
        r_pin      <= {DW{1'b1}};
        r_last_stb <= 1'b0;
        r_last_ack <= 1'b0;
        r_rdptr    <= {PW{1'b0}};
        r_wrptr    <= {PW{1'b0}};
        r_cnt      <= {CW{1'b0}};
      end else begin
        r_last_stb <= port_stb[gp];
        r_last_ack <= port_ack[gp];
        r_pin      <= w_pin;
        if (w_ctl_wr) begin
          r_dir  <= r_din[0];
          r_mode <= r_din[1];
          r_inte <= r_din[2];
        end
        if (w_dat_wr && !r_mode && !r_dir) begin
          r_latch <= r_din;
        end
        if (w_clear) begin
          r_rdptr <= {PW{1'b0}};
          r_wrptr <= {PW{1'b0}};
          r_cnt   <= {CW{1'b0}};
        end else begin
          if (w_do_pop) begin
            r_rdptr <= r_rdptr + PW'(1);
          end
          if (w_do_push) begin
            r_wrptr <= r_wrptr + PW'(1);
          end
          r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
        // A drop in the same cycle as a status read stays visible.
        if (w_clear) begin
          r_ovf <= 1'b0;
        end else if (w_drop) begin
          r_ovf <= 1'b1;
        end else if (w_st_rd) begin
          r_ovf <= 1'b0;
        end
      end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
      if (w_do_push && !w_clear) begin
        r_mem[r_wrptr] <= w_push_data;
      end
    end
  end

endmodule

// File: tb/tb_jt8255_multi.sv
module tb_jt8255_multi;
  logic        clk;
  logic        rstn;
  logic [2:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rdn;
  logic        wrn;
  logic        csn;
  logic        irq;
  logic [23:0] port_din;
  logic [23:0] port_dout;
  logic [2:0]  port_oe;
  logic [2:0]  port_stb;
  logic [2:0]  port_ack;
  logic [2:0]  port_rdy;
  logic [2:0]  port_obf;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected CPU read values, and models of the port FIFOs.
  logic [7:0] exp_q[$];
  logic [7:0] mq1[$];
  logic [7:0] mq2[$];

  jt8255_multi dut (
    .clk(clk), .rstn(rstn), .addr(addr), .din(din), .dout(dout),
    .rdn(rdn), .wrn(wrn), .csn(csn), .irq(irq),
    .port_din(port_din), .port_dout(port_dout), .port_oe(port_oe),
    .port_stb(port_stb), .port_ack(port_ack),
    .port_rdy(port_rdy), .port_obf(port_obf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; din = d; csn = 1'b0; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1; csn = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); addr = a; csn = 1'b0; rdn = 1'b0;
    @(negedge clk); d = dout; rdn = 1'b1; csn = 1'b1;
  endtask

  task automatic strobe(input int p, input logic [7:0] d);
    @(negedge clk); port_din[p*8 +: 8] = d; port_stb[p] = 1'b1;
    @(negedge clk); port_stb[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack(input int p);
    @(negedge clk); port_ack[p] = 1'b1;
    @(negedge clk); port_ack[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] d, e;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk);
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL reset_dout got=%h exp=ff", dout); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if ({port_oe, port_rdy, port_obf} !== 9'h000) begin bad++; $display("FAIL reset_flags got=%h exp=000", {port_oe, port_rdy, port_obf}); end
    total++; if (port_dout !== 24'hFFFFFF) begin bad++; $display("FAIL reset_port_dout got=%h exp=ffffff", port_dout); end
    rstn = 1'b1;
    exp_q.push_back(8'h01);
    cpu_read(3'b001, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL reset_status0 got=%h exp=%h", d, e); end
    port_din[7:0] = 8'h5A;
    exp_q.push_back(8'h5A);
    cpu_read(3'b000, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL mode0_in_read got=%h exp=%h", d, e); end
    total++; if (port_dout[7:0] !== 8'h5A) begin bad++; $display("FAIL mode0_in_passthru got=%h exp=5a", port_dout[7:0]); end
    exp_q.push_back(8'h00);
    cpu_read(3'b111, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL unmapped_read got=%h exp=%h", d, e); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_idle got=%b exp=0", irq); end
  endtask

  task automatic test_out_fifo;
    logic [7:0] d, e;
    logic [7:0] wv;
    cpu_write(3'b011, 8'h02);
    for (int i = 0; i < 5; i++) begin
      wv = 8'(8'h11 * (i + 1));
      cpu_write(3'b010, wv);
      if (mq1.size() < 4) mq1.push_back(wv);
    end
    total++; if (port_obf[1] !== 1'b1) begin bad++; $display("FAIL out_obf got=%b exp=1", port_obf[1]); end
    total++; if (port_oe[1] !== 1'b1) begin bad++; $display("FAIL out_oe got=%b exp=1", port_oe[1]); end
    total++; if (port_dout[15:8] !== mq1[0]) begin bad++; $display("FAIL out_head got=%h exp=%h", port_dout[15:8], mq1[0]); end
    exp_q.push_back(8'h4A);
    cpu_read(3'b011, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_status_ovf got=%h exp=%h", d, e); end
    exp_q.push_back(8'h0A);
    cpu_read(3'b011, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_status_ovf_clr got=%h exp=%h", d, e); end
    exp_q.push_back(mq1[0]);
    cpu_read(3'b010, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_peek got=%h exp=%h", d, e); end
    for (int i = 0; i < 4; i++) begin
      e = mq1.pop_front();
      total++; if (port_dout[15:8] !== e) begin bad++; $display("FAIL out_ack_data[%0d] got=%h exp=%h", i, port_dout[15:8], e); end
      ack(1);
    end
    total++; if (port_obf[1] !== 1'b0) begin bad++; $display("FAIL out_obf_empty got=%b exp=0", port_obf[1]); end
    total++; if (port_dout[15:8] !== 8'hFF) begin bad++; $display("FAIL out_empty_dout got=%h exp=ff", port_dout[15:8]); end
    ack(1);
    total++; if (port_obf[1] !== 1'b0) begin bad++; $display("FAIL out_ack_on_empty got=%b exp=0", port_obf[1]); end
  endtask

  task automatic test_in_irq;
    logic [7:0] d, e;
    cpu_write(3'b101, 8'h07);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL in_irq_idle got=%b exp=0", irq); end
    @(negedge clk); port_din[23:16] = 8'hA1; port_stb[2] = 1'b1; mq2.push_back(8'hA1);
    @(negedge clk); port_stb[2] = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL in_irq_latency got=%b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL in_irq_set got=%b exp=1", irq); end
    exp_q.push_back(mq2.pop_front());
    cpu_read(3'b100, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL in_pop_data got=%h exp=%h", d, e); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL in_irq_hold got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL in_irq_clear got=%b exp=0", irq); end
    exp_q.push_back(8'h17);
    cpu_read(3'b101, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL in_status_empty got=%h exp=%h", d, e); end
    exp_q.push_back(8'h00);
    cpu_read(3'b100, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL in_read_empty got=%h exp=%h", d, e); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, e;
    for (int i = 0; i < 4; i++) begin
      strobe(2, 8'(8'hB0 + i));
      mq2.push_back(8'(8'hB0 + i));
    end
    total++; if (port_rdy[2] !== 1'b0) begin bad++; $display("FAIL b2b_rdy_full got=%b exp=0", port_rdy[2]); end
    // CPU read first cycle and strobe rise land on the same clock edge.
    @(negedge clk); addr = 3'b100; csn = 1'b0; rdn = 1'b0; port_din[23:16] = 8'hC4; port_stb[2] = 1'b1;
    exp_q.push_back(mq2.pop_front()); mq2.push_back(8'hC4);
    @(negedge clk); d = dout; rdn = 1'b1; csn = 1'b1; port_stb[2] = 1'b0;
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL b2b_simul_data got=%h exp=%h", d, e); end
    exp_q.push_back(8'h2F);
    cpu_read(3'b101, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL b2b_simul_status got=%h exp=%h", d, e); end
    strobe(2, 8'hDD);
    exp_q.push_back(8'h6F);
    cpu_read(3'b101, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL b2b_in_ovf got=%h exp=%h", d, e); end
    strobe(2, 8'hDE);
    exp_q.push_back(mq2.pop_front());
    cpu_read(3'b100, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL b2b_pop_second got=%h exp=%h", d, e); end
    cpu_write(3'b101, 8'h0F);
    mq2.delete();
    total++; if (port_rdy[2] !== 1'b1) begin bad++; $display("FAIL flush_rdy got=%b exp=1", port_rdy[2]); end
    exp_q.push_back(8'h17);
    cpu_read(3'b101, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL flush_status got=%h exp=%h", d, e); end
    cpu_write(3'b101, 8'h00);
    cpu_write(3'b100, 8'h3C);
    total++; if (port_dout[23:16] !== 8'h3C) begin bad++; $display("FAIL mode0_out_dout got=%h exp=3c", port_dout[23:16]); end
    total++; if (port_oe[2] !== 1'b1) begin bad++; $display("FAIL mode0_out_oe got=%b exp=1", port_oe[2]); end
    exp_q.push_back(8'h3C);
    cpu_read(3'b100, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL mode0_out_read got=%h exp=%h", d, e); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d, e;
    cpu_write(3'b011, 8'h02);
    cpu_write(3'b010, 8'h66);
    cpu_write(3'b010, 8'h77);
    total++; if (port_obf[1] !== 1'b1) begin bad++; $display("FAIL mid_obf_before got=%b exp=1", port_obf[1]); end
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    total++; if (port_obf !== 3'b000) begin bad++; $display("FAIL mid_obf got=%b exp=000", port_obf); end
    total++; if (port_oe !== 3'b000) begin bad++; $display("FAIL mid_oe got=%b exp=000", port_oe); end
    total++; if (port_dout !== 24'hFFFFFF) begin bad++; $display("FAIL mid_port_dout got=%h exp=ffffff", port_dout); end
    exp_q.push_back(8'h01);
    cpu_read(3'b011, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL mid_status1 got=%h exp=%h", d, e); end
    exp_q.push_back(8'h01);
    cpu_read(3'b101, d); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL mid_status2 got=%h exp=%h", d, e); end
  endtask

  initial begin
    rstn = 1'b0; addr = 3'b000; din = 8'h00; rdn = 1'b1; wrn = 1'b1; csn = 1'b1;
    port_din = 24'h000000; port_stb = 3'b000; port_ack = 3'b000;
    repeat (2) @(negedge clk);
    test_reset;
    test_out_fifo;
    test_in_irq;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
